c3po_gather: RTL

//  Reverse path of the C3PO splitter: merges PORTS_P narrow 32-byte per-port packet streams into one
//  160-byte wide stream in the splitter's input format (sop/eop/val/vbc/id/data).

---
 rtl/c3po_gather_pkg.sv | 14 +
 rtl/c3po_rr_arb.sv | 47 ++++
 rtl/c3po_gather.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/c3po_gather_pkg.sv
// Shared constants and types for the C3PO gather block (narrow lanes -> wide word).
package c3po_gather_pkg;

    localparam int BEAT_BYTES     = 32;
    localparam int WORD_BYTES     = 160;
    localparam int BEATS_PER_WORD = 5;
    localparam int BEAT_W         = BEAT_BYTES * 8;
    localparam int WORD_W         = WORD_BYTES * 8;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} gather_state_t;

    typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/c3po_rr_arb.sv
// Round-robin arbiter: the first requester after the last winner gets the grant.
module c3po_rr_arb #(
    parameter int PORTS_P = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS_P-1:0] req,
    input  logic               upd,
    output logic [PORTS_P-1:0] gnt,
    output logic [3:0]         gnt_idx
);

    logic [3:0] ptr;
    logic       hit;

    // Ports above the pointer beat ports at or below it; the lowest index wins within each group.
    always_comb begin
        hit     = 1'b0;
        gnt_idx = '0;
        for (int p = PORTS_P - 1; p >= 0; p--) begin
            if (req[p] && (4'(p) <= ptr)) begin
                hit     = 1'b1;
                gnt_idx = 4'(p);
            end
        end
        for (int p = PORTS_P - 1; p >= 0; p--) begin
            if (req[p] && (4'(p) > ptr)) begin
                hit     = 1'b1;
                gnt_idx = 4'(p);
            end
        end
        gnt = '0;
        for (int p = 0; p < PORTS_P; p++) begin
            gnt[p] = hit && (gnt_idx == 4'(p));
        end
    end

    // Pointer follows the last winner; reset value makes port 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 4'(PORTS_P - 1);
        end else if (upd && hit) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/c3po_gather.sv
// Merges PORTS_P 32-byte packet lanes into one 160-byte word stream, five beats per word,
// with round-robin packet-level arbitration and per-port packet/error counters.
module c3po_gather
    import c3po_gather_pkg::*;
#(
    parameter int PORTS_P    = 4,
    parameter int CNT_SIZE_P = 8
) (
    input  logic                                   sig_clock,
    input  logic                                   sig_reset,
    input  logic [PORTS_P-1:0]                     sig_i_sop,
    input  logic [PORTS_P-1:0]                     sig_i_eop,
    input  logic [PORTS_P-1:0]                     sig_i_val,
    input  logic [PORTS_P-1:0][7:0]                sig_i_vbc,
    input  logic [PORTS_P-1:0][BEAT_W-1:0]         sig_i_data,
    output logic [PORTS_P-1:0]                     sig_i_ready,
    output logic                                   sig_sop,
    output logic                                   sig_eop,
    output logic                                   sig_val,
    output logic [7:0]                             sig_vbc,
    output logic [3:0]                             sig_id,
    output logic [WORD_W-1:0]                      sig_data,
    output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]     sig_pkt_cnt,
    output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]     sig_err_cnt
);

    // Byte count a beat contributes: only a well-formed eop beat may be short.
    function automatic logic [5:0] beat_bytes(logic eop, logic [7:0] vbc);
        if (eop && (vbc != 8'd0) && (vbc <= 8'(BEAT_BYTES))) return vbc[5:0];
        return 6'(BEAT_BYTES);
    endfunction

    // Zero every byte at or beyond nbytes so invalid bytes never reach the wide bus.
    function automatic beat_t zero_tail(beat_t d, logic [5:0] nbytes);
        beat_t m;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            m[j*8 +: 8] = (6'(j) < nbytes) ? d[j*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

    gather_state_t       state;
    logic [3:0]          owner;
    logic [PORTS_P-1:0]  own_oh;
    logic [2:0]          beat_idx;
    logic                sop_pend;
    logic [WORD_W-1:0]   word_p0;

    logic                own_val, own_sop, own_eop;
    logic [7:0]          own_vbc;
    beat_t               own_data;
    logic                accept, bad_vbc, mid_sop, emit;
    logic [5:0]          nbytes;
    logic [WORD_W-1:0]   word_nxt;
    logic [7:0]          vbc_nxt;
    logic [PORTS_P-1:0]  arb_req, arb_gnt, err_a, err_b, pkt_inc;
    logic [3:0]          arb_idx;

    assign arb_req = (state == IDLE) ? (sig_i_val & sig_i_sop) : '0;

    c3po_rr_arb #(.PORTS_P(PORTS_P)) u_arb (
        .clk     (sig_clock),
        .rst     (sig_reset),
        .req     (arb_req),
        .upd     (state == IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Select the owner's lane.
    always_comb begin
        own_val  = 1'b0;
        own_sop  = 1'b0;
        own_eop  = 1'b0;
        own_vbc  = '0;
        own_data = '0;
        for (int p = 0; p < PORTS_P; p++) begin
            if (own_oh[p]) begin
                own_val  = sig_i_val[p];
                own_sop  = sig_i_sop[p];
                own_eop  = sig_i_eop[p];
                own_vbc  = sig_i_vbc[p];
                own_data = sig_i_data[p];
            end
        end
    end

    // Beat acceptance, framing checks and the word being assembled.
    always_comb begin
        accept   = (state == LOCK) && own_val;
        bad_vbc  = own_eop && ((own_vbc == 8'd0) || (own_vbc > 8'(BEAT_BYTES)));
        mid_sop  = own_sop && !(sop_pend && (beat_idx == 3'd0));
        emit     = accept && (own_eop || (beat_idx == 3'(BEATS_PER_WORD - 1)));
        nbytes   = beat_bytes(own_eop, own_vbc);
        vbc_nxt  = {beat_idx, 5'd0} + {2'b00, nbytes};
        word_nxt = word_p0;
        for (int k = 0; k < BEATS_PER_WORD; k++) begin
            if (beat_idx == 3'(k)) word_nxt[k*BEAT_W +: BEAT_W] = zero_tail(own_data, nbytes);
        end
    end

    // Ready: owner only while locked; in IDLE, stray non-sop beats are drained so they cannot stall.
    always_comb begin
        if (state == LOCK) sig_i_ready = own_oh;
        else               sig_i_ready = sig_i_val & ~sig_i_sop;
    end

    // Per-port counter increments for this cycle.
    always_comb begin
        err_a   = '0;
        err_b   = '0;
        pkt_inc = '0;
        if (state == IDLE) begin
            err_a = sig_i_val & ~sig_i_sop;
        end else if (accept) begin
            if (mid_sop) err_a = own_oh;
            if (bad_vbc) err_b = own_oh;
            if (own_eop) pkt_inc = own_oh;
        end
    end

    // Grant/lock FSM, beat packing and output word register.
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            state    <= IDLE;
            owner    <= '0;
            own_oh   <= '0;
            beat_idx <= '0;
            sop_pend <= 1'b0;
            word_p0  <= '0;
            sig_val  <= 1'b0;
            sig_sop  <= 1'b0;
            sig_eop  <= 1'b0;
            sig_vbc  <= '0;
            sig_id   <= '0;
            sig_data <= '0;
        end else begin
            sig_val <= 1'b0;
            sig_sop <= 1'b0;
            sig_eop <= 1'b0;
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        state    <= LOCK;
                        owner    <= arb_idx;
                        own_oh   <= arb_gnt;
                        sop_pend <= 1'b1;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        if (emit) begin
                            sig_val  <= 1'b1;
                            sig_sop  <= sop_pend;
                            sig_eop  <= own_eop;
                            sig_vbc  <= vbc_nxt;
                            sig_id   <= owner;
                            sig_data <= word_nxt;
                            word_p0  <= '0;
                            beat_idx <= '0;
                            sop_pend <= 1'b0;
                        end else begin
                            word_p0  <= word_nxt;
                            beat_idx <= beat_idx + 3'd1;
                        end
                        if (own_eop) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Packet and error counters; both may step in one cycle, wrapping on overflow.
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            sig_pkt_cnt <= '0;
            sig_err_cnt <= '0;
        end else begin
            for (int p = 0; p < PORTS_P; p++) begin
                sig_pkt_cnt[p] <= sig_pkt_cnt[p] + CNT_SIZE_P'(pkt_inc[p]);
                sig_err_cnt[p] <= sig_err_cnt[p] + CNT_SIZE_P'(err_a[p]) + CNT_SIZE_P'(err_b[p]);
            end
        end
    end

endmodule
